imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into instruction memory.
// The CPU is held in reset until the image is complete. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_wen,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR
   } state_t;

   state_t      state;
   logic [15:0] count;
   logic [15:0] idx;
   logic [7:0]  hi_byte;
   logic        xfer;

   assign xfer = rx_valid & rx_ready;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
   logic       err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CNT_HI;
         rx_ready <= 1'b0;
         mem_wen  <= 1'b0;
         mem_addr <= BASE_ADDR;
         mem_data <= 16'h0000;
         cpu_rst  <= 1'b1;
         done     <= 1'b0;
         count    <= 16'h0000;
         idx      <= 16'h0000;
         hi_byte  <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
         csum     <= 8'h00;
         err_q    <= 1'b0;
`endif
      end else begin
         mem_wen <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         // The checksum byte itself is not folded into the running XOR.
         if (xfer && state != CHK)
            csum <= csum ^ rx_data;
`endif
         case (state)
            CNT_HI: begin
               rx_ready <= 1'b1;
               if (xfer) begin
                  hi_byte <= rx_data;
                  state   <= CNT_LO;
               end
            end
            CNT_LO: begin
               if (xfer) begin
                  count <= {hi_byte, rx_data};
                  if ({hi_byte, rx_data} == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                     state    <= CHK;
`else
                     state    <= DONE;
                     rx_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
`endif
                  end else begin
                     state <= DAT_HI;
                  end
               end
            end
            DAT_HI: begin
               if (xfer) begin
                  hi_byte <= rx_data;
                  state   <= DAT_LO;
               end
            end
            DAT_LO: begin
               if (xfer) begin
                  mem_wen  <= 1'b1;
                  mem_addr <= BASE_ADDR + idx;
                  mem_data <= {hi_byte, rx_data};
                  idx      <= idx + 16'd1;
                  if (idx == count - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                     state    <= CHK;
`else
                     state    <= DONE;
                     rx_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
`endif
                  end else begin
                     state <= DAT_HI;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (xfer) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                  end else begin
                     state <= ERR;
                     err_q <= 1'b1;
                  end
               end
            end
`endif
            DONE, ERR: begin
               if (load) begin
                  state    <= CNT_HI;
                  rx_ready <= 1'b1;
                  done     <= 1'b0;
                  cpu_rst  <= 1'b1;
                  idx      <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= 8'h00;
                  err_q    <= 1'b0;
`endif
               end
            end
            default: state <= CNT_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0x0000 and 0xFFFF) share one byte stream;
// written words are compared against a list-based model of the expected image.
module tb_imem_loader;

   localparam logic [15:0] B0 = 16'h0000;
   localparam logic [15:0] B1 = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst, load, rx_valid;
   logic [7:0]  rx_data;
   logic        rdy0, wen0, cpur0, done0, err0;
   logic        rdy1, wen1, cpur1, done1, err1;
   logic [15:0] addr0, data0, addr1, data1;

   imem_loader #(.BASE_ADDR(B0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy0), .mem_wen(wen0), .mem_addr(addr0), .mem_data(data0),
      .cpu_rst(cpur0), .done(done0), .err(err0));

   imem_loader #(.BASE_ADDR(B1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy1), .mem_wen(wen1), .mem_addr(addr1), .mem_data(data1),
      .cpu_rst(cpur1), .done(done1), .err(err1));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // observed writes, {addr, data}
   logic [31:0] wq0[$];
   logic [31:0] wq1[$];
   always @(negedge clk) begin
      if (wen0 === 1'b1) wq0.push_back({addr0, data0});
      if (wen1 === 1'b1) wq1.push_back({addr1, data1});
   end

   // reference model: image words -> byte stream and expected outcome
   logic [7:0]  stream[$];
   logic [15:0] words[$];
   bit          exp_ok;
   bit          chk_on;

   task automatic build(input logic [7:0] bad_mask);
      int n;
      logic [7:0] x;
      n = words.size();
      stream = {};
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      foreach (words[i]) begin
         stream.push_back(words[i][15:8]);
         stream.push_back(words[i][7:0]);
      end
      x = 8'h00;
      foreach (stream[i]) x = x ^ stream[i];
`ifdef LOADER_CHECKSUM_EN
      chk_on = 1'b1;
      stream.push_back(x ^ bad_mask);
      exp_ok = (bad_mask == 8'h00);
`else
      chk_on = 1'b0;
      exp_ok = 1'b1;
`endif
   endtask

   // starts and ends on a falling edge; ends on the edge right after the final transfer
   task automatic send(input int gmin, input int gmax, input bit rand_load);
      foreach (stream[i]) begin
         int g;
         int t;
         g = $urandom_range(gmax, gmin);
         repeat (g) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            load     = rand_load ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clk);
         end
         load     = 1'b0;
         rx_valid = 1'b1;
         rx_data  = stream[i];
         t = 0;
         while (rdy0 !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         check("rx_ready_wait0", rdy0, 1);
         check("rx_ready_wait1", rdy1, 1);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      load     = 1'b0;
   endtask

   task automatic finish_check(input string tag);
      int n;
      logic [15:0] a;
      n = words.size();
      check({tag, "_done0"}, done0, exp_ok);
      check({tag, "_done1"}, done1, exp_ok);
      check({tag, "_cpu_rst"}, cpur0, !exp_ok);
      check({tag, "_err"}, err0, !exp_ok);
      check({tag, "_rx_ready"}, rdy0, 0);
      check({tag, "_last_wen"}, wen0, (n > 0) && !chk_on);
      repeat (3) @(negedge clk);
      check({tag, "_nwrites0"}, wq0.size(), n);
      check({tag, "_nwrites1"}, wq1.size(), n);
      for (int i = 0; i < n && i < wq0.size() && i < wq1.size(); i++) begin
         a = B0 + 16'(i);
         check({tag, "_wr0"}, wq0[i], {a, words[i]});
         a = B1 + 16'(i);
         check({tag, "_wr1"}, wq1[i], {a, words[i]});
      end
      if (n > 0) begin
         a = B1 + 16'(n - 1);
         check({tag, "_hold_addr"}, addr1, a);
         check({tag, "_hold_data"}, data0, words[n-1]);
      end
      check({tag, "_hold_done"}, done0, exp_ok);
   endtask

   task automatic do_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("load_cpu_rst", cpur0, 1);
      check("load_done", done0, 0);
      check("load_err", err1, 0);
      check("load_rx_ready", rdy0, 1);
      wq0 = {};
      wq1 = {};
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; load = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_rx_ready", rdy0, 0);
      check("rst_wen", wen0, 0);
      check("rst_addr0", addr0, B0);
      check("rst_addr1", addr1, B1);
      check("rst_data", data0, 0);
      check("rst_cpu_rst", cpur0, 1);
      check("rst_done", done0, 0);
      check("rst_err", err0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rx_ready", rdy0, 1);

      words = {16'h1234, 16'hABCD};
      build(8'h00); send(0, 0, 0); finish_check("two_words");

      do_load();
      words = {};
      build(8'h00); send(0, 0, 0); finish_check("empty");

      do_load();
      words = {16'h55AA};
      build(8'h00); send(1, 1, 0); finish_check("toggle_valid");

      do_load();
      stream = {8'h00, 8'h02, 8'h12};
      send(0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_rx_ready", rdy0, 0);
      check("midrst_cpu_rst", cpur0, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_nwrites", wq0.size(), 0);
      check("midrst_rx_ready_up", rdy0, 1);
      words = {16'hBEEF};
      build(8'h00); send(0, 0, 0); finish_check("after_rst");

      do_load();
      words = {16'h1234};
      build(8'h00); send(0, 0, 0); finish_check("chk_good");

      do_load();
      words = {16'h1234};
      build(8'h27); send(0, 0, 0); finish_check("chk_bad");

      for (int k = 0; k < 12; k++) begin
         logic [7:0] mask;
         int n;
         do_load();
         words = {};
         n = $urandom_range(6, 0);
         for (int j = 0; j < n; j++) words.push_back(16'($urandom));
         mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         build(mask);
         send(0, 3, 1);
         finish_check("random");
      end

      do_load();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
